writeback_unit: RTL and testbench

Writeback stage of the RISC-V core, sitting directly upstream of the register file write port. Merges single-cycle ALU results with variable-latency load responses into one registered write (`wr_en`/`wr_index`/`wr_data`). Buffers load responses in a 2-entry FIFO with backpressure. Keeps a per-register scoreboard of outstanding loads so decode can detect read-after-write (RAW) hazards.

---
 rtl/writeback_unit_pkg.sv | 13 +
 rtl/writeback_unit_ldq.sv | 57 +++++
 rtl/writeback_unit.sv | 129 ++++++++++++
 tb/tb_writeback_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared writeback types: register index, load-queue entry and the x0 constant.
package writeback_unit_pkg;
    localparam int XLEN = 32;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/writeback_unit_ldq.sv
// wb_ldq: small circular FIFO holding load responses until the writeback port is free.
module wb_ldq
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  wb_entry_t     push_entry,
    input  logic          pop,
    output wb_entry_t     head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; emptiness is tracked solely by count_reg.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: ALU/load arbitration, registered RF write, load scoreboard, hazard detect.
// Optional operand forwarding from the pending write is enabled by defining WB_FWD_EN.
module writeback_unit #(
    parameter int XLEN      = 32,
    parameter int LDQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            wr_en,
    output logic [4:0]      wr_index,
    output logic [XLEN-1:0] wr_data,
    input  logic [4:0]      rs1_index,
    input  logic [4:0]      rs2_index,
    output logic            hazard,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2,
    output logic [31:0]     busy
);
    import writeback_unit_pkg::*;

    localparam int CW = $clog2(LDQ_DEPTH + 1);

    wb_entry_t       ld_entry;
    wb_entry_t       ldq_head;
    logic [CW-1:0]   ldq_count;
    logic            ldq_full;
    logic            ldq_empty;
    logic            ldq_push;
    logic            ldq_pop;

    logic            wr_en_reg,    wr_en_next;
    reg_idx_t        wr_index_reg, wr_index_next;
    logic [XLEN-1:0] wr_data_reg,  wr_data_next;
    logic [31:0]     busy_reg,     busy_next;
    logic            pend1;
    logic            pend2;

    assign ld_entry = '{rd: ld_rd, data: ld_data};
    assign ld_ready = (ldq_count < CW'(LDQ_DEPTH));
    assign ldq_push = ld_valid && ld_ready;
    assign ldq_pop  = !alu_valid && !ldq_empty;

    wb_ldq #(.DEPTH(LDQ_DEPTH), .CW(CW)) u_ldq (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (ldq_push),
        .push_entry (ld_entry),
        .pop        (ldq_pop),
        .head       (ldq_head),
        .count      (ldq_count),
        .full       (ldq_full),
        .empty      (ldq_empty)
    );

    // ALU has fixed priority; the queue head drains only in ALU-idle cycles.
    always_comb begin
        wr_en_next    = 1'b0;
        wr_index_next = wr_index_reg;
        wr_data_next  = wr_data_reg;
        busy_next     = busy_reg;
        if (alu_valid) begin
            wr_en_next    = (alu_rd != REG_ZERO);
            wr_index_next = alu_rd;
            wr_data_next  = alu_data;
        end else if (ldq_pop) begin
            wr_en_next             = (ldq_head.rd != REG_ZERO);
            wr_index_next          = ldq_head.rd;
            wr_data_next           = ldq_head.data;
            busy_next[ldq_head.rd] = 1'b0;
        end
        if (issue_valid && issue_rd != REG_ZERO)
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_reg    <= 1'b0;
            wr_index_reg <= REG_ZERO;
            wr_data_reg  <= '0;
            busy_reg     <= '0;
        end else begin
            wr_en_reg    <= wr_en_next;
            wr_index_reg <= wr_index_next;
            wr_data_reg  <= wr_data_next;
            busy_reg     <= busy_next;
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_index = wr_index_reg;
    assign wr_data  = wr_data_reg;
    assign busy     = busy_reg;

    assign pend1 = wr_en_reg && (wr_index_reg != REG_ZERO) && (wr_index_reg == rs1_index);
    assign pend2 = wr_en_reg && (wr_index_reg != REG_ZERO) && (wr_index_reg == rs2_index);

`ifdef WB_FWD_EN
    assign hazard    = busy_reg[rs1_index] | busy_reg[rs2_index];
    assign fwd_hit1  = pend1;
    assign fwd_hit2  = pend2;
    assign fwd_data1 = pend1 ? wr_data_reg : '0;
    assign fwd_data2 = pend2 ? wr_data_reg : '0;
`else
    assign hazard    = busy_reg[rs1_index] | busy_reg[rs2_index] | pend1 | pend2;
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

    // A second issue to a register whose load is still outstanding is illegal.
    a_no_double_issue: assert property (@(posedge clk) disable iff (!reset_n)
        !(issue_valid && issue_rd != REG_ZERO && busy_reg[issue_rd]));

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(ldq_push && ldq_full));
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed test-plan scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        wr_en;
    logic [4:0]  wr_index;
    logic [31:0] wr_data;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic        hazard;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [31:0] busy;

    writeback_unit dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .rs1_index(rs1_index), .rs2_index(rs2_index),
        .hazard(hazard), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_busy;
    logic        m_en;
    logic [4:0]  m_idx;
    logic [31:0] m_data;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = '0;
        m_en   = 1'b0;
        m_idx  = '0;
        m_data = '0;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        issue_valid = 0; issue_rd = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        rs1_index = 0; rs2_index = 0;
    endtask

    function automatic bit pending(input logic [4:0] rs);
        return m_en && (m_idx != 0) && (m_idx == rs);
    endfunction

    task automatic compare();
        bit p1, p2, hz;
        p1 = pending(rs1_index);
        p2 = pending(rs2_index);
        hz = (rs1_index != 0 && m_busy[rs1_index]) || (rs2_index != 0 && m_busy[rs2_index]);
        chk("ld_ready", 32'(ld_ready), 32'(m_q.size() < 2));
        chk("wr_en", 32'(wr_en), 32'(m_en));
        if (m_en) begin
            chk("wr_index", 32'(wr_index), 32'(m_idx));
            chk("wr_data", wr_data, m_data);
        end
        chk("busy", busy, m_busy);
`ifdef WB_FWD_EN
        chk("hazard", 32'(hazard), 32'(hz));
        chk("fwd_hit1", 32'(fwd_hit1), 32'(p1));
        chk("fwd_hit2", 32'(fwd_hit2), 32'(p2));
        if (p1) chk("fwd_data1", fwd_data1, m_data);
        if (p2) chk("fwd_data2", fwd_data2, m_data);
`else
        chk("hazard", 32'(hazard), 32'(hz || p1 || p2));
        chk("fwd_hit1", 32'(fwd_hit1), 32'd0);
        chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
        chk("fwd_data1", fwd_data1, 32'd0);
        chk("fwd_data2", fwd_data2, 32'd0);
`endif
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        logic        n_en;
        logic [4:0]  n_idx;
        logic [31:0] n_data;
        logic [31:0] nb;
        ent_t        e;
        bit          accept;
        #1;
        compare();
        accept = ld_valid && (m_q.size() < 2);
        n_en = 0; n_idx = m_idx; n_data = m_data;
        nb = m_busy;
        if (alu_valid) begin
            n_en = (alu_rd != 0); n_idx = alu_rd; n_data = alu_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            n_en = (e.rd != 0); n_idx = e.rd; n_data = e.data;
            nb[e.rd] = 1'b0;
        end
        if (accept) m_q.push_back('{rd: ld_rd, data: ld_data});
        if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
        nb[0] = 1'b0;
        @(posedge clk);
        m_en = n_en; m_idx = n_idx; m_data = n_data; m_busy = nb;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_index", 32'(wr_index), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_fwd_data1", fwd_data1, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        @(negedge clk);

        // ALU basic
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        chk("alu_wr_en", 32'(wr_en), 32'd1);
        chk("alu_wr_index", 32'(wr_index), 32'd5);
        chk("alu_wr_data", wr_data, 32'hDEADBEEF);
        tick();

        // Load path: issue x7 in N, response in N+3, write in N+5
        issue_valid = 1; issue_rd = 7;
        tick();
        idle_inputs();
        chk("ld_busy7_set", 32'(busy[7]), 32'd1);
        tick();
        rs1_index = 7;
        #1 chk("ld_hazard_rs1", 32'(hazard), 32'd1);
        tick();
        idle_inputs();
        ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
        tick();
        idle_inputs();
        tick();
        chk("ld_wr_en", 32'(wr_en), 32'd1);
        chk("ld_wr_index", 32'(wr_index), 32'd7);
        chk("ld_wr_data", wr_data, 32'h1234);
        chk("ld_busy7_clr", 32'(busy[7]), 32'd0);
        tick();

        // Priority and backpressure: ALU held 6 cycles, 3 loads offered
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'(i);
            ld_valid = (i < 3); ld_rd = 5'(20 + i); ld_data = 32'h100 + 32'(i);
            #1 chk("bp_ld_ready", 32'(ld_ready), (i < 2) ? 32'd1 : 32'd0);
            tick();
        end
        idle_inputs();
        tick();
        chk("bp_first_idx", 32'(wr_index), 32'd20);
        chk("bp_first_data", wr_data, 32'h100);
        tick();
        chk("bp_second_idx", 32'(wr_index), 32'd21);
        chk("bp_second_data", wr_data, 32'h101);
        tick();
        chk("bp_drained", 32'(wr_en), 32'd0);

        // x0 suppression
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        tick();
        idle_inputs();
        chk("x0_alu_wr_en", 32'(wr_en), 32'd0);
        ld_valid = 1; ld_rd = 0; ld_data = 32'h77;
        tick();
        idle_inputs();
        tick();
        chk("x0_ld_wr_en", 32'(wr_en), 32'd0);
        issue_valid = 1; issue_rd = 0;
        tick();
        idle_inputs();
        chk("x0_busy", busy, 32'd0);

        // Forwarding of a pending write to rs2
        alu_valid = 1; alu_rd = 3; alu_data = 32'hA5A5A5A5;
        tick();
        idle_inputs();
        rs2_index = 3;
        #1;
`ifdef WB_FWD_EN
        chk("fwd_hit2", 32'(fwd_hit2), 32'd1);
        chk("fwd_data2", fwd_data2, 32'hA5A5A5A5);
        chk("fwd_hazard", 32'(hazard), 32'd0);
`else
        chk("nofwd_hazard", 32'(hazard), 32'd1);
        chk("nofwd_hit2", 32'(fwd_hit2), 32'd0);
`endif
        tick();
        idle_inputs();

        // Reset mid-operation: FIFO full, busy = 0x80
        issue_valid = 1; issue_rd = 7;
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            alu_valid = 1; alu_rd = 1; alu_data = 32'hF0 + 32'(i);
            ld_valid = 1; ld_rd = 5'(9 + i); ld_data = 32'(i);
            tick();
        end
        alu_valid = 1; ld_valid = 0;
        #1;
        chk("mid_ld_ready_full", 32'(ld_ready), 32'd0);
        chk("mid_busy", busy, 32'h80);
        #1 reset_n = 1'b0;
        idle_inputs();
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        chk("mid_fifo_empty", 32'(wr_en), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int alu_pct;
            alu_pct = (((i / 200) % 3) == 0) ? 90 : 45;
            alu_valid   = ($urandom_range(0, 99) < alu_pct);
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            ld_valid    = ($urandom_range(0, 99) < 60);
            ld_rd       = 5'($urandom_range(0, 7));
            ld_data     = $urandom;
            issue_rd    = 5'($urandom_range(0, 7));
            issue_valid = ($urandom_range(0, 99) < 30) && !m_busy[issue_rd];
            rs1_index   = 5'($urandom_range(0, 7));
            rs2_index   = 5'($urandom_range(0, 7));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
